mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage load/store engine that sits directly downstream of the EX/MEM pipeline register.
- Consumes the registered address, store data, MemRead/MemWrite, StoreType, LoadType and ExcCode, and runs one bus transaction per memory instruction.
- Produces the aligned, extended load result for the MEM/WB register.
- Asserts Mem_Stall to the hazard unit so that EX/MEM holds its contents until the access completes.

Parameters:
- TIMEOUT, 16: maximum wait cycles for bus_ack before the access is aborted as a bus error (must be ≥2).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- ALU_result  in  32  effective byte address
- Memory_Write_data  in  32  store source register value
- MemRead  in  1  load instruction in MEM
- MemWrite  in  1  store instruction in MEM
- StoreType  in  2  0=sw, 1=sh, 2=sb, 3=reserved (treated as sw)
- LoadType  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, others treated as lw
- ExcCode  in  2  exception already raised upstream (0=none)
- MEM_Stall_ext  in  1  downstream stall; MEM/WB is not accepting
- bus_ack  in  1  slave completion strobe, one cycle
- bus_rdata  in  32  read data, valid with bus_ack
- bus_req  out  1  registered request
- bus_we  out  1  registered write enable
- bus_addr  out  32  registered word address {addr[31:2],2'b00}
- bus_be  out  4  registered byte enables
- bus_wdata  out  32  registered lane-replicated store data
- Mem_Stall  out  1  hold EX/MEM and upstream
- Load_data  out  32  formatted load result, held until next load completes
- Mem_ExcCode  out  2  0=none, 1=AdEL, 2=AdES, 3=bus error; nonzero ExcCode passes through

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - All registered outputs go to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, Load_data, and the error flag.
  - Reset mid-transaction drops bus_req immediately; the transaction is abandoned.
- Access qualification: access = (MemRead|MemWrite) & ExcCode==0 & aligned.
- Alignment rules:
  - Word accesses need addr[1:0]==0.
  - Halfword accesses need addr[0]==0.
  - Byte accesses are always aligned.
- Misaligned access: no bus request, Mem_Stall=0, Mem_ExcCode = 1 for a load or 2 for a store.
- If MemRead and MemWrite are both set, the store takes precedence.
- Byte enables:
  - sw: 1111
  - sh: 0011 when addr[1]=0, 1100 when addr[1]=1
  - sb: 0001<<addr[1:0]
- Store data replication: sw passes the word through, sh drives {h,h}, sb drives {b,b,b,b}.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If access, load the bus_* registers, go to WAIT, and clear the timeout counter.
  - Mem_Stall = access (combinational).
- WAIT:
  - bus_req=1 and Mem_Stall=1.
  - On bus_ack: drop bus_req; for a load, register Load_data from bus_rdata; go to DONE.
  - If no ack when the counter reaches TIMEOUT-1: drop bus_req, set the bus error flag, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- DONE:
  - Mem_Stall=0; Load_data is valid; Mem_ExcCode=3 if the error flag is set.
  - If !MEM_Stall_ext, go to IDLE; the EX/MEM register advances on the same edge.
  - Otherwise stay in DONE holding data, with no reissue.
  - Leaving DONE clears the error flag.
- Load formatting:
  - Lane selection: byte lane = addr[1:0]; halfword lane = addr[1].
  - lh and lb sign-extend; lhu and lbu zero-extend.
- Latency: minimum 3 cycles per access (IDLE accept, WAIT with ack, DONE).
- Non-memory instructions: 0 stall cycles.
- bus_ack seen outside WAIT is ignored.
- Exactly one bus transaction per instruction instance.

Test Plan:
- lw at 0x1000_0004, ack one cycle after req, rdata 0xDEADBEEF:
  - Mem_Stall is high for 2 cycles; bus_be=1111, bus_addr=0x1000_0004.
  - Load_data=0xDEADBEEF in DONE.
- lb at 0x...03 with rdata 0x80FF_0000 → Load_data=0xFFFFFF80; the same access with lbu → 0x00000080.
- sb at 0x...02 with data 0x0000_00A5 → bus_we=1, bus_be=0100, bus_wdata=0xA5A5A5A5; Load_data unchanged.
- sh at 0x...01 → no bus_req, Mem_Stall=0, Mem_ExcCode=2.
- lw with ExcCode=1 → no bus_req, Mem_ExcCode=1.
- lw with no ack and TIMEOUT=16:
  - bus_req is high exactly 16 cycles, then drops.
  - DONE presents Mem_ExcCode=3.
- Reset and stall corner cases:
  - Reset asserted mid-WAIT → bus_req=0 asynchronously; state returns to IDLE.
  - MEM_Stall_ext held 3 cycles in DONE → no reissue; Load_data stable.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store engine, one bus transaction per memory instruction
// Ports: clk/reset (async, active-low); EX/MEM inputs ALU_result, Memory_Write_data,
//   MemRead, MemWrite, StoreType, LoadType, ExcCode; MEM_Stall_ext from MEM/WB;
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata registered bus request, bus_ack/bus_rdata reply;
//   Mem_Stall to the hazard unit, Load_data formatted load result, Mem_ExcCode exception out.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Memory_Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  ExcCode,
  input  logic        MEM_Stall_ext,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        Mem_Stall,
  output logic [31:0] Load_data,
  output logic [1:0]  Mem_ExcCode
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [1:0]    w_sz;
  logic          w_mem, w_aligned, w_access, w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_fmt;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  assign w_mem = MemRead | MemWrite;
  // Access size: 0=word, 1=half, 2=byte; a store wins when both strobes are set.
  assign w_sz = MemWrite ? (StoreType == 2'd1 ? 2'd1 : StoreType == 2'd2 ? 2'd2 : 2'd0)
              : (LoadType == 3'd1 || LoadType == 3'd2) ? 2'd1
              : (LoadType == 3'd3 || LoadType == 3'd4) ? 2'd2 : 2'd0;
  assign w_aligned = w_sz == 2'd0 ? ALU_result[1:0] == 2'b00 : w_sz == 2'd1 ? ~ALU_result[0] : 1'b1;
  assign w_access  = w_mem & (ExcCode == 2'd0) & w_aligned;
  assign w_be = w_sz == 2'd0 ? 4'b1111 : w_sz == 2'd1 ? (ALU_result[1] ? 4'b1100 : 4'b0011)
              : 4'b0001 << ALU_result[1:0];
  assign w_wdata = w_sz == 2'd0 ? Memory_Write_data : w_sz == 2'd1 ? {2{Memory_Write_data[15:0]}}
                 : {4{Memory_Write_data[7:0]}};
  // EX/MEM is held while we stall, so the live address/type still describe the access in flight.
  assign w_byte = bus_rdata[{ALU_result[1:0], 3'b000} +: 8];
  assign w_half = ALU_result[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign w_fmt = LoadType == 3'd1 ? {{16{w_half[15]}}, w_half}
               : LoadType == 3'd2 ? {16'h0000, w_half}
               : LoadType == 3'd3 ? {{24{w_byte[7]}}, w_byte}
               : LoadType == 3'd4 ? {24'h000000, w_byte} : bus_rdata;
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  assign Mem_ExcCode = ExcCode != 2'd0 ? ExcCode
                     : (r_state == DONE && r_err) ? 2'd3
                     : (w_mem & ~w_aligned) ? (MemWrite ? 2'd2 : 2'd1) : 2'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    Mem_Stall = 1'b0;
    case (r_state)
      IDLE: begin
        Mem_Stall = w_access;
        w_next    = w_access ? WAIT : IDLE;
      end
      WAIT: begin
        Mem_Stall = 1'b1;
        w_next    = (bus_ack | w_timeout) ? DONE : WAIT;
      end
      DONE: w_next = MEM_Stall_ext ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      Load_data <= 32'h0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_access) begin
          bus_req   <= 1'b1;
          bus_we    <= MemWrite;
          bus_addr  <= {ALU_result[31:2], 2'b00};
          bus_be    <= w_be;
          bus_wdata <= w_wdata;
          r_cnt     <= '0;
        end
        // An ack in the timeout cycle takes priority over the error.
        WAIT: if (bus_ack) begin
          bus_req <= 1'b0;
          if (!bus_we) Load_data <= w_fmt;
        end else if (w_timeout) begin
          bus_req <= 1'b0;
          r_err   <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        DONE: if (!MEM_Stall_ext) r_err <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_result, Memory_Write_data, bus_rdata;
  logic        MemRead, MemWrite, MEM_Stall_ext, bus_ack;
  logic [1:0]  StoreType, ExcCode;
  logic [2:0]  LoadType;
  logic        bus_req, bus_we, Mem_Stall;
  logic [31:0] bus_addr, bus_wdata, Load_data;
  logic [3:0]  bus_be;
  logic [1:0]  Mem_ExcCode;
  int n_cmp = 0;
  int n_bad = 0;
  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ALU_result(ALU_result), .Memory_Write_data(Memory_Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .StoreType(StoreType), .LoadType(LoadType),
    .ExcCode(ExcCode), .MEM_Stall_ext(MEM_Stall_ext), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .Mem_Stall(Mem_Stall), .Load_data(Load_data), .Mem_ExcCode(Mem_ExcCode)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] st, input logic [2:0] lt, input logic [1:0] ex);
    MemRead = rd; MemWrite = wr; ALU_result = a; Memory_Write_data = d;
    StoreType = st; LoadType = lt; ExcCode = ex;
  endtask
  task automatic nop();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 3'd0, 2'd0);
    bus_ack = 1'b0;
    MEM_Stall_ext = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    nop();
    bus_rdata = 32'h0;
    #12;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus_req); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin n_bad++; $display("FAIL rst_bus got %b %h %h %h want zeros", bus_we, bus_be, bus_addr, bus_wdata); end
    n_cmp++; if (Load_data !== 32'h0) begin n_bad++; $display("FAIL rst_load got %h want 0", Load_data); end
    n_cmp++; if ({Mem_Stall, Mem_ExcCode} !== 3'b000) begin n_bad++; $display("FAIL rst_stall_exc got %b %d want 0 0", Mem_Stall, Mem_ExcCode); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask
  task automatic test_lw();
    drive(1'b1, 1'b0, 32'h1000_0004, 32'h0, 2'd0, 3'd0, 2'd0);
    #1;
    n_cmp++; if ({Mem_Stall, bus_req} !== 2'b10) begin n_bad++; $display("FAIL lw_idle stall/req got %b%b want 10", Mem_Stall, bus_req); end
    tick();
    n_cmp++; if ({Mem_Stall, bus_req, bus_we} !== 3'b110) begin n_bad++; $display("FAIL lw_wait stall/req/we got %b%b%b want 110", Mem_Stall, bus_req, bus_we); end
    n_cmp++; if (bus_addr !== 32'h1000_0004) begin n_bad++; $display("FAIL lw_addr got %h want 10000004", bus_addr); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", bus_be); end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if ({Mem_Stall, bus_req} !== 2'b00) begin n_bad++; $display("FAIL lw_done stall/req got %b%b want 00", Mem_Stall, bus_req); end
    n_cmp++; if (Load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", Load_data); end
    n_cmp++; if (Mem_ExcCode !== 2'd0) begin n_bad++; $display("FAIL lw_exc got %d want 0", Mem_ExcCode); end
    tick();
    nop();
  endtask
  task automatic test_load_fmt();
    logic [2:0]  lt [4]  = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [31:0] ad [4]  = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0002};
    logic [31:0] rd [4]  = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ad[i], 32'h0, 2'd0, lt[i], 2'd0);
      tick();
      if (i == 0) begin
        n_cmp++; if (bus_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", bus_be); end
      end
      if (i == 2) begin
        n_cmp++; if (bus_be !== 4'b1100) begin n_bad++; $display("FAIL lh_be got %b want 1100", bus_be); end
      end
      bus_ack = 1'b1; bus_rdata = rd[i];
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (Load_data !== exp[i]) begin n_bad++; $display("FAIL load_fmt[%0d] got %h want %h", i, Load_data, exp[i]); end
      tick();
      nop();
    end
  endtask
  task automatic test_sb();
    drive(1'b0, 1'b1, 32'h1000_0002, 32'h0000_00A5, 2'd2, 3'd0, 2'd0);
    #1;
    n_cmp++; if (Mem_Stall !== 1'b1) begin n_bad++; $display("FAIL sb_idle_stall got %b want 1", Mem_Stall); end
    tick();
    n_cmp++; if ({bus_req, bus_we} !== 2'b11) begin n_bad++; $display("FAIL sb_req_we got %b%b want 11", bus_req, bus_we); end
    n_cmp++; if (bus_be !== 4'b0100) begin n_bad++; $display("FAIL sb_be got %b want 0100", bus_be); end
    n_cmp++; if (bus_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got %h want a5a5a5a5", bus_wdata); end
    n_cmp++; if (bus_addr !== 32'h1000_0000) begin n_bad++; $display("FAIL sb_addr got %h want 10000000", bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (Load_data !== 32'h0000_8001) begin n_bad++; $display("FAIL sb_load_kept got %h want 00008001", Load_data); end
    tick();
    nop();
  endtask
  task automatic test_sh_store_both();
    drive(1'b1, 1'b1, 32'h1000_0006, 32'h0000_BEEF, 2'd1, 3'd0, 2'd0);
    tick();
    n_cmp++; if ({bus_req, bus_we, bus_be} !== 6'b11_1100) begin n_bad++; $display("FAIL both_store got %b%b %b want 11 1100", bus_req, bus_we, bus_be); end
    n_cmp++; if (bus_wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_wdata got %h want beefbeef", bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    nop();
  endtask
  task automatic test_misaligned();
    drive(1'b0, 1'b1, 32'h1000_0001, 32'h0, 2'd1, 3'd0, 2'd0);
    #1;
    n_cmp++; if ({Mem_Stall, Mem_ExcCode} !== 3'b0_10) begin n_bad++; $display("FAIL sh_mis got stall %b exc %d want 0 2", Mem_Stall, Mem_ExcCode); end
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL sh_mis_req got %b want 0", bus_req); end
    drive(1'b1, 1'b0, 32'h1000_0002, 32'h0, 2'd0, 3'd0, 2'd0);
    #1;
    n_cmp++; if ({Mem_Stall, Mem_ExcCode} !== 3'b0_01) begin n_bad++; $display("FAIL lw_mis got stall %b exc %d want 0 1", Mem_Stall, Mem_ExcCode); end
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL lw_mis_req got %b want 0", bus_req); end
    nop();
  endtask
  task automatic test_upstream_exc();
    drive(1'b1, 1'b0, 32'h1000_0000, 32'h0, 2'd0, 3'd0, 2'd1);
    #1;
    n_cmp++; if ({Mem_Stall, Mem_ExcCode} !== 3'b0_01) begin n_bad++; $display("FAIL exc_pass got stall %b exc %d want 0 1", Mem_Stall, Mem_ExcCode); end
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL exc_req got %b want 0", bus_req); end
    nop();
    #1;
    n_cmp++; if (Mem_Stall !== 1'b0) begin n_bad++; $display("FAIL nop_stall got %b want 0", Mem_Stall); end
  endtask
  task automatic test_timeout();
    int cnt = 0;
    drive(1'b1, 1'b0, 32'h2000_0000, 32'h0, 2'd0, 3'd0, 2'd0);
    tick();
    for (int i = 0; i < 40 && bus_req; i++) begin
      cnt++;
      tick();
    end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL timeout_len got %0d want 16", cnt); end
    n_cmp++; if ({Mem_Stall, Mem_ExcCode} !== 3'b0_11) begin n_bad++; $display("FAIL timeout_exc got stall %b exc %d want 0 3", Mem_Stall, Mem_ExcCode); end
    tick();
    nop();
    #1;
    n_cmp++; if (Mem_ExcCode !== 2'd0) begin n_bad++; $display("FAIL err_clear got %d want 0", Mem_ExcCode); end
  endtask
  task automatic test_ack_at_timeout();
    drive(1'b1, 1'b0, 32'h2000_0004, 32'h0, 2'd0, 3'd0, 2'd0);
    tick();
    repeat (15) tick();
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL late_req got %b want 1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (Mem_ExcCode !== 2'd0) begin n_bad++; $display("FAIL late_ack_exc got %d want 0", Mem_ExcCode); end
    n_cmp++; if (Load_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL late_ack_data got %h want cafef00d", Load_data); end
    tick();
    nop();
  endtask
  task automatic test_stall_ext();
    drive(1'b1, 1'b0, 32'h1000_0008, 32'h0, 2'd0, 3'd0, 2'd0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0;
    MEM_Stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_ack = (i == 1);
      bus_rdata = 32'hFFFF_FFFF;
      tick();
      n_cmp++; if ({bus_req, Mem_Stall} !== 2'b00) begin n_bad++; $display("FAIL hold_req[%0d] got %b%b want 00", i, bus_req, Mem_Stall); end
      n_cmp++; if (Load_data !== 32'h1122_3344) begin n_bad++; $display("FAIL hold_data[%0d] got %h want 11223344", i, Load_data); end
    end
    bus_ack = 1'b0;
    MEM_Stall_ext = 1'b0;
    tick();
    nop();
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL no_reissue got %b want 0", bus_req); end
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h3000_0000, 32'h0, 2'd0, 3'd0, 2'd0);
    tick();
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got %b want 1", bus_req); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_async got %b want 0", bus_req); end
    n_cmp++; if (Load_data !== 32'h0) begin n_bad++; $display("FAIL rmid_load got %h want 0", Load_data); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if ({Mem_Stall, bus_req} !== 2'b10) begin n_bad++; $display("FAIL rmid_idle got %b%b want 10", Mem_Stall, bus_req); end
    tick();
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_reissue got %b want 1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (Load_data !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rmid_data got %h want 0badf00d", Load_data); end
    tick();
    nop();
  endtask
  initial begin
    test_reset();
    test_lw();
    test_load_fmt();
    test_sb();
    test_sh_store_both();
    test_misaligned();
    test_upstream_exc();
    test_timeout();
    test_ack_at_timeout();
    test_stall_ext();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
